// File: rtl/core_lsu_mem_resp_if.sv
// -----------------------------------------------------------------------------
// core_lsu_mem_resp_if
//
// Request/response bundle between an LSU (master) and the memory responder
// (slave).
//
//   req_valid  LSU -> mem   request present
//   req_ready  mem -> LSU   responder can accept a request
//   req_addr   LSU -> mem   byte address, bits [1:0] ignored
//   req_wen    LSU -> mem   1 = store, 0 = load
//   req_wdata  LSU -> mem   store data, already byte-lane aligned
//   req_wmask  LSU -> mem   byte enables, bit i enables byte i
//   rsp_valid  mem -> LSU   response present
//   rsp_ready  LSU -> mem   LSU accepts the response
//   rsp_rdata  mem -> LSU   load data, full aligned word (0 for stores/errors)
//   rsp_err    mem -> LSU   access out of range
// -----------------------------------------------------------------------------
interface core_lsu_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/core_lsu_mem_resp.sv
// -----------------------------------------------------------------------------
// core_lsu_mem_resp
//
// Single-outstanding memory responder for an LSU. A request is accepted in
// IDLE; stores commit to the word array on the acceptance edge and load data
// is captured into a response register at the same time. The response is
// presented RSP_LAT cycles after acceptance and held until the LSU takes it.
//
// Parameters
//   MEM_AW   log2 of memory depth in 32-bit words
//   RSP_LAT  cycles from acceptance to first rsp_valid (1..15)
//
// Ports
//   clk      single clock, rising edge
//   rst      synchronous, active-high reset (memory contents are kept)
//   bus      core_lsu_mem_resp_if.slave request/response bundle
//
// Build option
//   CORE_LSU_MEM_RESP_RAND_STALL_EN  adds 0..3 extra wait cycles per request,
//   taken from bits [1:0] of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed
//   8'h01) that advances once per accepted request.
// -----------------------------------------------------------------------------
module core_lsu_mem_resp #(
    parameter int MEM_AW  = 10,
    parameter int RSP_LAT = 2
) (
    input logic                 clk,
    input logic                 rst,
    core_lsu_mem_resp_if.slave  bus
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam int CW    = 5;   // holds RSP_LAT-1 plus up to 3 stall cycles

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic [MEM_AW-1:0] idx;
    logic [CW-1:0]     wait_cycles;
    logic [1:0]        unused_addr_lsb;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // A request arriving while rst is high must not commit a store.
    assign accept   = bus.req_valid && (state == IDLE) && !rst;
    assign idx      = bus.req_addr[MEM_AW+1:2];
    assign in_range = (bus.req_addr[31:MEM_AW+2] == '0);

    // Word alignment is implied; the byte offset is intentionally dropped.
    assign unused_addr_lsb = bus.req_addr[1:0];

`ifdef CORE_LSU_MEM_RESP_RAND_STALL_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Taps 8,6,5,4 map to bits 7,5,4,3.
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign wait_cycles = CW'(RSP_LAT - 1) + CW'(lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'h01;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign wait_cycles = CW'(RSP_LAT - 1);
`endif

    // NOTE: the array has no reset branch on purpose -- contents survive rst,
    // and a reset-free array maps onto block RAM instead of flops.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wen && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_wmask[b]) begin
                    mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // NOTE: every state register here uses <= so all updates see the values
    // from before the edge; e.g. a load reads the pre-store word, never a
    // value written in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_q   <= !in_range;
                        rdata_q <= (in_range && !bus.req_wen) ? mem[idx] : 32'h0;
                        if (wait_cycles == '0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= wait_cycles;
                        end
                    end
                end
                WAIT: begin
                    // Leave on the edge where the count reaches zero.
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_lsu_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_core_lsu_mem_resp
//
// Directed bench: one responder with RSP_LAT=2 runs a table of load/store
// vectors plus backpressure; a second with RSP_LAT=4 covers reset during WAIT.
// All driving and sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_core_lsu_mem_resp;
    logic clk = 1'b0;
    logic rst2;
    logic rst4;

    always #5 clk = ~clk;

    core_lsu_mem_resp_if b2();
    core_lsu_mem_resp_if b4();

    core_lsu_mem_resp #(.MEM_AW(10), .RSP_LAT(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2.slave));
    core_lsu_mem_resp #(.MEM_AW(10), .RSP_LAT(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] lfsr_m;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wmask, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Extra stall cycles expected for the next accepted request on dut2.
    function automatic int next_extra();
        int e;
`ifdef CORE_LSU_MEM_RESP_RAND_STALL_EN
        logic fb;
        e  = int'(lfsr_m[1:0]);
        fb = lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3];
        lfsr_m = {lfsr_m[6:0], fb};
`else
        e = 0;
`endif
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic txn2(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output logic [31:0] rdata, output logic err,
                        output int lat, output int exp_lat);
        int n;
        n = 0;
        while (!b2.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        b2.req_valid = 1'b1;
        b2.req_wen   = wen;
        b2.req_addr  = addr;
        b2.req_wdata = wdata;
        b2.req_wmask = wmask;
        b2.rsp_ready = 1'b1;
        exp_lat = 2 + next_extra();
        @(negedge clk);
        b2.req_valid = 1'b0;
        lat = 1;
        while (!b2.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata = b2.rsp_rdata;
        err   = b2.rsp_err;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          exp_lat;
        int          seen;

        vecs[0]  = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
        vecs[1]  = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        vecs[2]  = mk(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0);
        vecs[3]  = mk(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0,      1'b0);
        vecs[4]  = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
        vecs[5]  = mk(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0);
        vecs[6]  = mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
        vecs[7]  = mk(1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        vecs[8]  = mk(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
        vecs[9]  = mk(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1);
        vecs[10] = mk(1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1);
        vecs[11] = mk(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
        vecs[12] = mk(1'b1, 32'h0000_0FFC, 32'h0BAD_C0DE, 4'hF, 32'h0,         1'b0);
        vecs[13] = mk(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0);
        vecs[14] = mk(1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0,         1'b1);
        vecs[15] = mk(1'b1, 32'h0000_0FFC, 32'h0000_0000, 4'b1000, 32'h0,      1'b0);
        vecs[16] = mk(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h00AD_C0DE, 1'b0);

        // Reset both responders.
        rst2 = 1'b1; rst4 = 1'b1;
        b2.req_valid = 1'b0; b2.req_wen = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
        b2.req_wmask = '0;   b2.rsp_ready = 1'b1;
        b4.req_valid = 1'b0; b4.req_wen = 1'b0; b4.req_addr = '0; b4.req_wdata = '0;
        b4.req_wmask = '0;   b4.rsp_ready = 1'b1;
        lfsr_m = 8'h01;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; rst4 = 1'b0;
        check("rst_req_ready",  32'(b2.req_ready), 32'h1);
        check("rst_rsp_valid",  32'(b2.rsp_valid), 32'h0);
        check("rst_rsp_rdata",  b2.rsp_rdata,      32'h0);
        check("rst_rsp_err",    32'(b2.rsp_err),   32'h0);
        check("rst4_req_ready", 32'(b4.req_ready), 32'h1);
        check("rst4_rsp_valid", 32'(b4.rsp_valid), 32'h0);

        // Table of transactions on the RSP_LAT=2 responder.
        for (int i = 0; i < 17; i++) begin
            txn2(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rdata, err, lat, exp_lat);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat));
        end

        // Backpressure: response held for 5 cycles; a request offered meanwhile
        // is ignored.
        b2.rsp_ready = 1'b0;
        b2.req_valid = 1'b1; b2.req_wen = 1'b0; b2.req_addr = 32'h10; b2.req_wmask = 4'h0;
        exp_lat = 2 + next_extra();
        @(negedge clk);
        b2.req_valid = 1'b0;
        lat = 1;
        while (!b2.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(exp_lat));
        b2.req_valid = 1'b1; b2.req_wen = 1'b1; b2.req_addr = 32'h20;
        b2.req_wdata = 32'h0; b2.req_wmask = 4'hF;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_rsp_valid", c), 32'(b2.rsp_valid), 32'h1);
            check($sformatf("bp%0d_rsp_rdata", c), b2.rsp_rdata, 32'hDEAD_BEEF);
            check($sformatf("bp%0d_req_ready", c), 32'(b2.req_ready), 32'h0);
            if (c < 4) @(negedge clk);
        end
        b2.req_valid = 1'b0;
        b2.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_req_ready", 32'(b2.req_ready), 32'h1);
        check("bp_after_rsp_valid", 32'(b2.rsp_valid), 32'h0);
        txn2(1'b0, 32'h20, 32'h0, 4'h0, rdata, err, lat, exp_lat);
        check("bp_ignored_store", rdata, 32'h11BB_33DD);

        // Reset during WAIT on the RSP_LAT=4 responder; the store stays.
        b4.req_valid = 1'b1; b4.req_wen = 1'b1; b4.req_addr = 32'h40;
        b4.req_wdata = 32'h55AA_55AA; b4.req_wmask = 4'hF;
        @(negedge clk);
        b4.req_valid = 1'b0;
        check("rw_in_wait_valid", 32'(b4.rsp_valid), 32'h0);
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("rw_req_ready", 32'(b4.req_ready), 32'h1);
        check("rw_rsp_valid", 32'(b4.rsp_valid), 32'h0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b4.rsp_valid) seen++;
        end
        check("rw_no_response", 32'(seen), 32'h0);
        b4.req_valid = 1'b1; b4.req_wen = 1'b0; b4.req_addr = 32'h40;
        @(negedge clk);
        b4.req_valid = 1'b0;
        lat = 1;
        while (!b4.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
`ifdef CORE_LSU_MEM_RESP_RAND_STALL_EN
        check("rw_load_latency", 32'(lat), 32'd5);   // first LFSR value after reset is 8'h01
`else
        check("rw_load_latency", 32'(lat), 32'd4);
`endif
        check("rw_store_kept", b4.rsp_rdata, 32'h55AA_55AA);
        @(negedge clk);

`ifdef CORE_LSU_MEM_RESP_RAND_STALL_EN
        // Randomised stalls must follow the LFSR reference sequence.
        for (int i = 0; i < 64; i++) begin
            txn2(1'b0, 32'h10, 32'h0, 4'h0, rdata, err, lat, exp_lat);
            check($sformatf("stall%0d_latency", i), 32'(lat), 32'(exp_lat));
            check($sformatf("stall%0d_rdata", i), rdata, 32'hDEAD_BEEF);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
